// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit driving a word-only DataMem port.
// Sub-word stores are done as read-modify-write; misaligned/illegal
// requests are answered with resp_err without touching memory.
// Optional: define LSU_RANGE_CHECK_EN to trap byte addresses above the
// 2^ADDR_W-word memory instead of letting them alias.
module lsu_rmw #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Byte-address bits that map into the memory.
  localparam int unsigned AW = ADDR_W + 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [2:0]    f3_q;
  logic [31:0]   wdata_q;

  logic width_ok_c;
  logic align_ok_c;
  logic range_ok_c;
  logic legal_c;

`ifdef LSU_RANGE_CHECK_EN
  assign range_ok_c = (req_addr[31:AW] == '0);
`else
  logic unused_hi_addr;
  assign unused_hi_addr = ^req_addr[31:AW];
  assign range_ok_c     = 1'b1;
`endif

  // Decode width/alignment legality of the incoming request.
  always_comb begin
    width_ok_c = 1'b0;
    align_ok_c = 1'b0;
    if (req_we) begin
      width_ok_c = ~req_funct3[2] && (req_funct3[1:0] != 2'b11);
    end else begin
      width_ok_c = (req_funct3[1:0] != 2'b11) && (req_funct3 != 3'd6);
    end
    case (req_funct3[1:0])
      2'b00:   align_ok_c = 1'b1;
      2'b01:   align_ok_c = ~req_addr[0];
      2'b10:   align_ok_c = (req_addr[1:0] == 2'b00);
      default: align_ok_c = 1'b0;
    endcase
  end

  assign legal_c = width_ok_c && align_ok_c && range_ok_c;

  // Extract and extend the addressed lane of a loaded word.
  function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                           input logic [1:0]  lane,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half lane of the old word with store data.
  function automatic logic [31:0] merge_lane(input logic        half,
                                             input logic [1:0]  lane,
                                             input logic [31:0] old_w,
                                             input logic [31:0] wd);
    logic [31:0] r;
    r = old_w;
    if (half) begin
      r[{lane[1], 4'b0000} +: 16] = wd[15:0];
    end else begin
      r[{lane, 3'b000} +: 8] = wd[7:0];
    end
    return r;
  endfunction

  // Request FSM with captured request fields and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      f3_q       <= '0;
      wdata_q    <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr[AW-1:0];
            f3_q    <= req_funct3;
            wdata_q <= req_wdata;
            if (!legal_c) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (req_funct3[1:0] == 2'b10) begin
              state <= WRITE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          resp_err   <= 1'b0;
          resp_rdata <= load_ext(f3_q, addr_q[1:0], mem_rdata);
          state      <= RESP;
        end
        RMW_RD: begin
          wdata_q <= merge_lane(f3_q[0], addr_q[1:0], mem_rdata, wdata_q);
          state   <= WRITE;
        end
        WRITE: begin
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory port and handshake strobes decoded from the state register.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_read   = (state == LOAD) || (state == RMW_RD);
  assign mem_write  = (state == WRITE);
  assign mem_addr   = (state == IDLE) ? '0 : addr_q[AW-1:2];
  assign mem_wdata  = (state == WRITE) ? wdata_q : '0;

endmodule
